// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, owner codes and
// the return-path tag carried alongside each granted command.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CORE       = 2'd1,
        ST_EXT        = 2'd2,
        ST_EXT_LOCKED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   is_read;
    } ret_tag_t;

    localparam ret_tag_t TAG_NONE = '{owner: OWN_NONE, is_read: 1'b0};

endpackage

// File: rtl/mem_arb_ret_pipe.sv
// Return path: two-stage tag pipeline tracking the owner of each read, then
// steering the RAM read data to that owner with a one-cycle rvalid.
module mem_arb_ret_pipe
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  ret_tag_t              i_tag,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    output logic [DATA_WIDTH-1:0] o_core_rdata,
    output logic                  o_core_rvalid,
    output logic [DATA_WIDTH-1:0] o_ext_rdata,
    output logic                  o_ext_rvalid
);

    ret_tag_t              r_tag_s1;
    ret_tag_t              r_tag_s2;
    logic                  r_core_rvalid;
    logic                  r_ext_rvalid;
    logic [DATA_WIDTH-1:0] r_core_rdata;
    logic [DATA_WIDTH-1:0] r_ext_rdata;
    logic                  w_core_ret;
    logic                  w_ext_ret;

    // Stage 2 lines up with the cycle in which the RAM presents read data.
    assign w_core_ret = r_tag_s2.is_read && (r_tag_s2.owner == OWN_CORE);
    assign w_ext_ret  = r_tag_s2.is_read && (r_tag_s2.owner == OWN_EXT);

    always_ff @(posedge clk) begin
        if (arst) begin
            r_tag_s1      <= TAG_NONE;
            r_tag_s2      <= TAG_NONE;
            r_core_rvalid <= 1'b0;
            r_ext_rvalid  <= 1'b0;
            r_core_rdata  <= '0;
            r_ext_rdata   <= '0;
        end else begin
            r_tag_s1      <= i_tag;
            r_tag_s2      <= r_tag_s1;
            r_core_rvalid <= w_core_ret;
            r_ext_rvalid  <= w_ext_ret;
            if (w_core_ret) r_core_rdata <= i_ram_rdata;
            if (w_ext_ret)  r_ext_rdata  <= i_ram_rdata;
        end
    end

    assign o_core_rdata  = r_core_rdata;
    assign o_core_rvalid = r_core_rvalid;
    assign o_ext_rdata   = r_ext_rdata;
    assign o_ext_rvalid  = r_ext_rvalid;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (core, external) in front of a single-port synchronous RAM.
// Define MEM_ARB_STARVE_EN to force an ext grant after STARVE_LIMIT waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rvalid,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    input  logic                  ext_lock,
    output logic                  ext_gnt,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ext_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_core_gnt;
    logic                  w_ext_gnt;
    logic                  w_starve;
    ret_tag_t              w_tag;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_ram_we;

`ifdef MEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] r_starve_cnt;

    always_ff @(posedge clk) begin
        if (arst || w_ext_gnt)
            r_starve_cnt <= '0;
        else if (ext_req && (r_starve_cnt != CNT_W'(STARVE_LIMIT)))
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end

    assign w_starve = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign w_starve = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (arst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EXT_LOCKED: if (!ext_lock) w_state_nxt = ST_IDLE;
            default: begin
                if (w_core_gnt)     w_state_nxt = ST_CORE;
                else if (w_ext_gnt) w_state_nxt = ext_lock ? ST_EXT_LOCKED : ST_EXT;
                else                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grants are combinational so a request can transfer in the cycle it appears.
    always_comb begin
        w_core_gnt = 1'b0;
        w_ext_gnt  = 1'b0;
        if (!arst) begin
            case (r_state)
                ST_EXT_LOCKED: w_ext_gnt = ext_req;
                default: begin
                    if (w_starve && ext_req) begin
                        w_ext_gnt = 1'b1;
                    end else begin
                        w_core_gnt = core_req;
                        w_ext_gnt  = ext_req && !core_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_tag         = TAG_NONE;
        if (w_core_gnt) begin
            w_tag.owner   = OWN_CORE;
            w_tag.is_read = !core_we;
        end else if (w_ext_gnt) begin
            w_tag.owner   = OWN_EXT;
            w_tag.is_read = !ext_we;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
        end else begin
            r_ram_we <= (w_core_gnt && core_we) || (w_ext_gnt && ext_we);
            if (w_core_gnt) begin
                r_ram_addr  <= core_addr;
                r_ram_wdata <= core_wdata;
            end else if (w_ext_gnt) begin
                r_ram_addr  <= ext_addr;
                r_ram_wdata <= ext_wdata;
            end
        end
    end

    mem_arb_ret_pipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ret_pipe (
        .clk           (clk),
        .arst          (arst),
        .i_tag         (w_tag),
        .i_ram_rdata   (ram_rdata),
        .o_core_rdata  (core_rdata),
        .o_core_rvalid (core_rvalid),
        .o_ext_rdata   (ext_rdata),
        .o_ext_rvalid  (ext_rvalid)
    );

    assign core_gnt  = w_core_gnt;
    assign ext_gnt   = w_ext_gnt;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 Parameter STARVE_LIMIT, default 4, ext wait cycles before forced grant (used only with MEM_ARB_STARVE_EN).
REQ-004 Ports: clk input 1, clock; arst input 1, reset (synchronous, active-high).
REQ-005 Core side: core_req in 1; core_we in 1; core_addr in ADDR_WIDTH; core_wdata in DATA_WIDTH; core_gnt out 1; core_rdata out DATA_WIDTH; core_rvalid out 1.
REQ-006 External side: ext_req in 1; ext_we in 1; ext_addr in ADDR_WIDTH; ext_wdata in DATA_WIDTH; ext_lock in 1, hold ownership; ext_gnt out 1; ext_rdata out DATA_WIDTH; ext_rvalid out 1.
REQ-007 RAM side: ram_addr out ADDR_WIDTH; ram_wdata out DATA_WIDTH; ram_we out 1; ram_rdata in DATA_WIDTH, valid one cycle after ram_addr is presented.

Function
REQ-008 Transfer occurs in cycle T when req and gnt are both high; gnt is combinational from req, FSM state and starvation flag.
REQ-009 core_gnt and ext_gnt are never high in the same cycle; at most one transfer per cycle.
REQ-010 Requester holds req, we, addr, wdata stable until granted.
REQ-011 Granted command is registered onto ram_addr/ram_wdata/ram_we in T+1; ram_we is high for exactly one cycle per write.
REQ-012 Read data is captured from ram_rdata in T+2 and driven on the owner's rdata with rvalid high for one cycle in T+3; writes produce no rvalid.
REQ-013 Return routing uses a 2-stage tag pipeline (owner, is_read); back-to-back reads from either side return in grant order, one per cycle.
REQ-014 FSM states: IDLE, CORE, EXT, EXT_LOCKED.
REQ-015 IDLE/CORE/EXT: core_req wins over ext_req (fixed priority); state becomes the granted owner, or IDLE when no req.
REQ-016 An ext grant with ext_lock high enters EXT_LOCKED; core_gnt stays low in EXT_LOCKED.
REQ-017 EXT_LOCKED exits to IDLE on the first cycle ext_lock is low; the lock cannot be entered without an ext grant.
REQ-018 When no request is granted, ram_we is 0 and ram_addr/ram_wdata hold their last value.
REQ-019 rdata outputs hold their last value when rvalid is low.

Reset
REQ-020 While arst is high at a clk edge: state IDLE, ram_we 0, ram_addr 0, ram_wdata 0, rdata 0, rvalid 0, tag pipeline cleared, starvation counter 0.
REQ-021 Reads in flight at reset are dropped; no rvalid is produced for them after reset deasserts.
REQ-022 While arst is high, gnt outputs are 0.

Configuration
REQ-023 Macro MEM_ARB_STARVE_EN defined: counter counts cycles with ext_req high and ext_gnt low, saturating at STARVE_LIMIT.
REQ-024 With MEM_ARB_STARVE_EN, when the count equals STARVE_LIMIT, the next cycle with ext_req grants ext even if core_req is high; the counter clears on ext grant.
REQ-025 MEM_ARB_STARVE_EN undefined: strict core priority; no counter logic is synthesised.

Structure
REQ-026 Shared package mem_arb_pkg holds the FSM state encoding and owner codes (OWN_NONE=0, OWN_CORE=1, OWN_EXT=2).
REQ-027 The return tag pipeline and read-data steering are the sub-module mem_arb_ret_pipe; arbitration and the FSM stay in mem_arbiter.

Verification
REQ-028 Core reads addr 0x10 (RAM holds 0x5A) -> core_gnt in T, ram_addr 0x10 in T+1, core_rdata 0x5A with core_rvalid in T+3.
REQ-029 core_req and ext_req both high in the same cycle, strict build -> core_gnt only; ext_gnt in the first cycle core_req is low.
REQ-030 Ext write 0x33 to 0x20 with ext_lock held 3 cycles while core_req is high -> ram_we pulse at 0x20 with 0x33; no core_gnt until the cycle after ext_lock drops.
REQ-031 MEM_ARB_STARVE_EN, STARVE_LIMIT 4, core_req and ext_req held high continuously -> ext_gnt on cycle 5; core is granted again next.
REQ-032 Alternating core/ext reads of 0x01 and 0x02 back-to-back -> rvalid alternates core/ext with the correct data in grant order.
REQ-033 arst asserted in T+1 after a core read grant -> no core_rvalid afterwards; all outputs at reset values.
